pwm_multi_gen: RTL and testbench

- Parametrised multi-channel PWM / frequency generator. It is the next generation of the fixed-ratio toggle dividers in the PWM tree.
- One shared period counter drives NUM_CH independent duty comparators.
- Period and duty are runtime-programmable with glitch-free, boundary-aligned reload.
- Reset defaults reproduce the existing 175 kHz 50% square wave: 572 clk cycles per period at 100 MHz.

---
 rtl/pwm_pkg.sv | 20 ++
 rtl/pwm_ch_cmp.sv | 42 ++++
 rtl/pwm_multi_gen.sv | 90 +++++++++
 tb/tb_pwm_multi_gen.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared defaults and duty-bus slicing helper for the PWM generator
package pwm_pkg;

  localparam int DEF_CNT_W  = 16;
  localparam int DEF_PERIOD = 571;
  localparam int DEF_DUTY   = 286;

  // Upper bounds for the generic slicing helper; callers cast the result down to CNT_W.
  localparam int MAX_CNT_W  = 32;
  localparam int MAX_BUS_W  = 1024;

  function automatic logic [MAX_CNT_W-1:0] duty_slice(input logic [MAX_BUS_W-1:0] bus,
                                                      input int unsigned          ch,
                                                      input int unsigned          w);
    logic [MAX_CNT_W-1:0] mask;
    mask = {MAX_CNT_W{1'b1}} >> (MAX_CNT_W - w);
    return MAX_CNT_W'(bus >> (ch * w)) & mask;
  endfunction

endpackage

// File: rtl/pwm_ch_cmp.sv
// rtl/pwm_ch_cmp.sv - one PWM channel: staged/active duty and registered compare against the shared counter
module pwm_ch_cmp
  import pwm_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int RST_DUTY = DEF_DUTY,
  parameter bit INVERT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] duty_in,
  input  logic             stage,
  input  logic             direct,
  input  logic             apply,
  output logic             pwm
);

  logic [CNT_W-1:0] duty_st;
  logic [CNT_W-1:0] duty_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_st <= CNT_W'(RST_DUTY);
      duty_sh <= CNT_W'(RST_DUTY);
      pwm     <= INVERT;
    end else begin
      if (stage) begin
        duty_st <= duty_in;
      end
      // A load landing on the terminal cycle bypasses staging entirely.
      if (direct) begin
        duty_sh <= duty_in;
      end else if (apply) begin
        duty_sh <= duty_st;
      end
      pwm <= en ? ((cnt < duty_sh) ^ INVERT) : INVERT;
    end
  end

endmodule

// File: rtl/pwm_multi_gen.sv
// rtl/pwm_multi_gen.sv - multi-channel PWM generator with a shared period counter and boundary-aligned reload
module pwm_multi_gen #(
  parameter int CNT_W      = pwm_pkg::DEF_CNT_W,
  parameter int NUM_CH     = 4,
  parameter int DEF_PERIOD = pwm_pkg::DEF_PERIOD,
  parameter int DEF_DUTY   = pwm_pkg::DEF_DUTY,
  parameter bit INVERT     = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [CNT_W-1:0]        period_in,
  input  logic [NUM_CH*CNT_W-1:0] duty_in,
  input  logic                    load,
  output logic                    load_pending,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    period_tick,
  output logic [CNT_W-1:0]        cnt_out
);

  import pwm_pkg::*;

  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     per_sh;
  logic [CNT_W-1:0]     per_st;
  logic                 pend;
  logic                 term;
  logic                 direct;
  logic                 apply;
  logic [MAX_BUS_W-1:0] duty_bus;

  assign term     = (cnt == per_sh);
  assign direct   = load & en & term;
  // While disabled the counter already sits at 0, so staged values may go live at once.
  assign apply    = pend & (~en | term) & ~direct;
  assign duty_bus = MAX_BUS_W'(duty_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      per_sh      <= CNT_W'(DEF_PERIOD);
      per_st      <= CNT_W'(DEF_PERIOD);
      pend        <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      cnt         <= (!en || term) ? '0 : cnt + 1'b1;
      period_tick <= en & term;
      if (load) begin
        per_st <= period_in;
      end
      if (direct) begin
        per_sh <= period_in;
      end else if (apply) begin
        per_sh <= per_st;
      end
      if (direct) begin
        pend <= 1'b0;
      end else if (load) begin
        pend <= 1'b1;
      end else if (apply) begin
        pend <= 1'b0;
      end
    end
  end

  assign load_pending = pend;
  assign cnt_out      = cnt;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] duty_ch;
    assign duty_ch = CNT_W'(duty_slice(duty_bus, i, CNT_W));

    pwm_ch_cmp #(
      .CNT_W    (CNT_W),
      .RST_DUTY (DEF_DUTY),
      .INVERT   (INVERT)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .cnt     (cnt),
      .duty_in (duty_ch),
      .stage   (load),
      .direct  (direct),
      .apply   (apply),
      .pwm     (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi_gen.sv
// tb/tb_pwm_multi_gen.sv - randomized self-checking bench for pwm_multi_gen against a phase/period model
module tb_pwm_multi_gen;

  localparam int CNT_W  = 16;
  localparam int NUM_CH = 4;
  localparam bit INV    = 1'b0;
  localparam logic [NUM_CH-1:0] IDLE = {NUM_CH{INV}};
  localparam logic [NUM_CH-1:0] BUSY = {NUM_CH{~INV}};

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    en = 1'b0;
  logic                    load = 1'b0;
  logic [CNT_W-1:0]        period_in = '0;
  logic [NUM_CH*CNT_W-1:0] duty_in = '0;
  logic                    load_pending;
  logic                    period_tick;
  logic [NUM_CH-1:0]       pwm_out;
  logic [CNT_W-1:0]        cnt_out;

  int vectors = 0;
  int miscompares = 0;

  pwm_multi_gen #(
    .CNT_W(CNT_W), .NUM_CH(NUM_CH), .DEF_PERIOD(571), .DEF_DUTY(286), .INVERT(INV)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .period_in(period_in), .duty_in(duty_in), .load(load),
    .load_pending(load_pending), .pwm_out(pwm_out), .period_tick(period_tick), .cnt_out(cnt_out)
  );

  always #5 clk = ~clk;

  // Reference: a period of m_len cycles, position m_phase, channel high while phase < duty.
  int                m_len, m_phase, s_len;
  int                m_duty [NUM_CH];
  int                s_duty [NUM_CH];
  bit                m_pend, e_tick;
  logic [NUM_CH-1:0] e_pwm;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_len = 572; s_len = 572; m_pend = 0; e_tick = 0; e_pwm = IDLE;
      for (int i = 0; i < NUM_CH; i++) begin m_duty[i] = 286; s_duty[i] = 286; end
    end else begin : step
      bit last;
      last   = (m_phase == m_len - 1);
      e_tick = en && last;
      for (int i = 0; i < NUM_CH; i++) e_pwm[i] = en ? ((m_phase < m_duty[i]) ^ INV) : INV;
      if (load && en && last) begin
        m_len = int'(period_in) + 1;
        for (int i = 0; i < NUM_CH; i++) m_duty[i] = int'(duty_in[i*CNT_W +: CNT_W]);
        m_pend = 0;
      end else begin
        if (m_pend && (!en || last)) begin
          m_len = s_len; m_duty = s_duty; m_pend = 0;
        end
        if (load) begin
          s_len = int'(period_in) + 1;
          for (int i = 0; i < NUM_CH; i++) s_duty[i] = int'(duty_in[i*CNT_W +: CNT_W]);
          m_pend = 1;
        end
      end
      m_phase = (!en || last) ? 0 : m_phase + 1;
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; en = 0; load = 0;
    repeat (2) cyc();
    vectors++;
    if (pwm_out !== IDLE || period_tick !== 1'b0 || cnt_out !== '0 || load_pending !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: pwm=%b tick=%b cnt=%0d pend=%b, expected pwm=%b tick=0 cnt=0 pend=0",
               pwm_out, period_tick, cnt_out, load_pending, IDLE);
    end
    rst = 0;
  endtask

  task automatic test_defaults();
    int last_tick, ticks;
    int hi [NUM_CH];
    last_tick = -1; ticks = 0;
    for (int i = 0; i < NUM_CH; i++) hi[i] = 0;
    en = 1;
    for (int c = 0; c < 1300; c++) begin
      cyc();
      vectors++;
      if (pwm_out !== e_pwm || period_tick !== e_tick || load_pending !== m_pend || cnt_out !== CNT_W'(m_phase)) begin
        miscompares++;
        $display("FAIL defaults: pwm got %b exp %b, tick got %b exp %b, pend got %b exp %b, cnt got %0d exp %0d",
                 pwm_out, e_pwm, period_tick, e_tick, load_pending, m_pend, cnt_out, m_phase);
      end
      for (int i = 0; i < NUM_CH; i++) if (pwm_out[i] ^ INV) hi[i]++;
      if (period_tick) begin
        if (last_tick >= 0) begin
          vectors++;
          if (c - last_tick != 572) begin
            miscompares++;
            $display("FAIL defaults tick spacing: got %0d exp 572", c - last_tick);
          end
          for (int i = 0; i < NUM_CH; i++) begin
            vectors++;
            if (hi[i] != 286) begin
              miscompares++;
              $display("FAIL defaults high count ch%0d: got %0d exp 286", i, hi[i]);
            end
          end
        end
        last_tick = c; ticks++;
        for (int i = 0; i < NUM_CH; i++) hi[i] = 0;
      end
    end
    vectors++;
    if (ticks != 2) begin
      miscompares++;
      $display("FAIL defaults tick count: got %0d exp 2", ticks);
    end
  endtask

  task automatic test_mid_reload();
    int n, pend_cyc, ticks;
    int hi [NUM_CH];
    int want [NUM_CH];
    want = '{0, 6, 20, 20};
    for (n = 0; n < 700 && m_phase != 100; n++) begin
      cyc();
      vectors++;
      if (pwm_out !== e_pwm || period_tick !== e_tick || load_pending !== m_pend || cnt_out !== CNT_W'(m_phase)) begin
        miscompares++;
        $display("FAIL mid_reload wait: pwm got %b exp %b, tick got %b exp %b, pend got %b exp %b, cnt got %0d exp %0d",
                 pwm_out, e_pwm, period_tick, e_tick, load_pending, m_pend, cnt_out, m_phase);
      end
    end
    vectors++;
    if (m_phase != 100) begin miscompares++; $display("FAIL mid_reload timeout: phase %0d exp 100", m_phase); end
    load = 1; period_in = 9; duty_in = {16'd20, 16'd10, 16'd3, 16'd0};
    pend_cyc = 0;
    for (int k = 0; k < 472; k++) begin
      cyc();
      load = 0;
      vectors++;
      if (pwm_out !== e_pwm || period_tick !== e_tick || load_pending !== m_pend || cnt_out !== CNT_W'(m_phase)) begin
        miscompares++;
        $display("FAIL mid_reload pend: pwm got %b exp %b, tick got %b exp %b, pend got %b exp %b, cnt got %0d exp %0d",
                 pwm_out, e_pwm, period_tick, e_tick, load_pending, m_pend, cnt_out, m_phase);
      end
      if (load_pending) pend_cyc++;
    end
    vectors++;
    if (pend_cyc != 471) begin miscompares++; $display("FAIL mid_reload pending cycles: got %0d exp 471", pend_cyc); end
    ticks = 0;
    for (int i = 0; i < NUM_CH; i++) hi[i] = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      vectors++;
      if (pwm_out !== e_pwm || period_tick !== e_tick || load_pending !== m_pend || cnt_out !== CNT_W'(m_phase)) begin
        miscompares++;
        $display("FAIL mid_reload new: pwm got %b exp %b, tick got %b exp %b, pend got %b exp %b, cnt got %0d exp %0d",
                 pwm_out, e_pwm, period_tick, e_tick, load_pending, m_pend, cnt_out, m_phase);
      end
      for (int i = 0; i < NUM_CH; i++) if (pwm_out[i] ^ INV) hi[i]++;
      if (period_tick) ticks++;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      vectors++;
      if (hi[i] != want[i]) begin
        miscompares++;
        $display("FAIL mid_reload high count ch%0d: got %0d exp %0d", i, hi[i], want[i]);
      end
    end
    vectors++;
    if (ticks != 2) begin miscompares++; $display("FAIL mid_reload ticks: got %0d exp 2", ticks); end
  endtask

  task automatic test_term_load();
    int n, ticks;
    for (n = 0; n < 30 && m_phase != 5; n++) cyc();
    load = 1; period_in = 14; duty_in = {16'd4, 16'd3, 16'd2, 16'd1};
    cyc();
    load = 0;
    for (n = 0; n < 30 && m_phase != 9; n++) begin
      vectors++;
      if (pwm_out !== e_pwm || period_tick !== e_tick || load_pending !== m_pend || cnt_out !== CNT_W'(m_phase)) begin
        miscompares++;
        $display("FAIL term_load stage: pwm got %b exp %b, tick got %b exp %b, pend got %b exp %b, cnt got %0d exp %0d",
                 pwm_out, e_pwm, period_tick, e_tick, load_pending, m_pend, cnt_out, m_phase);
      end
      cyc();
    end
    load = 1; period_in = 6; duty_in = {16'd5, 16'd2, 16'd0, 16'd7};
    cyc();
    load = 0;
    vectors++;
    if (load_pending !== 1'b0 || cnt_out !== '0) begin
      miscompares++;
      $display("FAIL term_load direct: pend got %b exp 0, cnt got %0d exp 0", load_pending, cnt_out);
    end
    ticks = 0;
    for (int k = 0; k < 21; k++) begin
      cyc();
      vectors++;
      if (pwm_out !== e_pwm || period_tick !== e_tick || load_pending !== m_pend || cnt_out !== CNT_W'(m_phase)
          || cnt_out > 6) begin
        miscompares++;
        $display("FAIL term_load run: pwm got %b exp %b, tick got %b exp %b, pend got %b exp %b, cnt got %0d exp %0d (max 6)",
                 pwm_out, e_pwm, period_tick, e_tick, load_pending, m_pend, cnt_out, m_phase);
      end
      if (period_tick) ticks++;
    end
    vectors++;
    if (ticks != 3) begin miscompares++; $display("FAIL term_load ticks: got %0d exp 3", ticks); end
  endtask

  task automatic test_enable();
    int n, ticks, hi1, hi2;
    load = 1; period_in = 399; duty_in = {16'd450, 16'd300, 16'd200, 16'd100};
    cyc();
    load = 0;
    for (n = 0; n < 700 && (m_pend || m_phase != 200); n++) cyc();
    vectors++;
    if (cnt_out !== 16'd200 || load_pending !== 1'b0) begin
      miscompares++;
      $display("FAIL enable setup: cnt got %0d exp 200, pend got %b exp 0", cnt_out, load_pending);
    end
    en = 0;
    cyc();
    vectors++;
    if (cnt_out !== '0 || pwm_out !== IDLE || period_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL enable drop: cnt got %0d exp 0, pwm got %b exp %b, tick got %b exp 0",
               cnt_out, pwm_out, IDLE, period_tick);
    end
    load = 1; period_in = 4; duty_in = {16'd1, 16'd5, 16'd0, 16'd2};
    cyc();
    load = 0;
    vectors++;
    if (load_pending !== 1'b1) begin miscompares++; $display("FAIL enable staged: pend got %b exp 1", load_pending); end
    cyc();
    vectors++;
    if (load_pending !== 1'b0 || pwm_out !== IDLE) begin
      miscompares++;
      $display("FAIL enable applied: pend got %b exp 0, pwm got %b exp %b", load_pending, pwm_out, IDLE);
    end
    en = 1;
    ticks = 0; hi1 = 0; hi2 = 0;
    for (int k = 0; k < 16; k++) begin
      cyc();
      vectors++;
      if (pwm_out !== e_pwm || period_tick !== e_tick || load_pending !== m_pend || cnt_out !== CNT_W'(m_phase)
          || (k == 0 && cnt_out !== 16'd1)) begin
        miscompares++;
        $display("FAIL enable run: pwm got %b exp %b, tick got %b exp %b, pend got %b exp %b, cnt got %0d exp %0d",
                 pwm_out, e_pwm, period_tick, e_tick, load_pending, m_pend, cnt_out, m_phase);
      end
      if (period_tick) ticks++;
      if (pwm_out[1] ^ INV) hi1++;
      if (pwm_out[2] ^ INV) hi2++;
    end
    vectors++;
    if (ticks != 3 || hi1 != 0 || hi2 != 16) begin
      miscompares++;
      $display("FAIL enable period: ticks got %0d exp 3, ch1 high got %0d exp 0, ch2 high got %0d exp 16", ticks, hi1, hi2);
    end
  endtask

  task automatic test_zero_period();
    int n;
    load = 1; period_in = 0; duty_in = {NUM_CH{16'd1}};
    cyc();
    load = 0;
    for (n = 0; n < 20 && m_pend; n++) cyc();
    cyc();
    for (int k = 0; k < 10; k++) begin
      cyc();
      vectors++;
      if (period_tick !== 1'b1 || pwm_out !== BUSY || cnt_out !== '0) begin
        miscompares++;
        $display("FAIL zero_period duty1: tick got %b exp 1, pwm got %b exp %b, cnt got %0d exp 0",
                 period_tick, pwm_out, BUSY, cnt_out);
      end
    end
    load = 1; duty_in = '0;
    cyc();
    load = 0;
    cyc();
    for (int k = 0; k < 10; k++) begin
      cyc();
      vectors++;
      if (period_tick !== 1'b1 || pwm_out !== IDLE || load_pending !== 1'b0) begin
        miscompares++;
        $display("FAIL zero_period duty0: tick got %b exp 1, pwm got %b exp %b, pend got %b exp 0",
                 period_tick, pwm_out, IDLE, load_pending);
      end
    end
  endtask

  task automatic test_reset_pending();
    int n, last_tick, ticks;
    load = 1; period_in = 100; duty_in = {NUM_CH{16'd50}};
    cyc();
    load = 0;
    for (n = 0; n < 300 && (m_pend || m_phase != 30); n++) cyc();
    load = 1; period_in = 7; duty_in = {NUM_CH{16'd3}};
    cyc();
    load = 0;
    vectors++;
    if (load_pending !== 1'b1) begin miscompares++; $display("FAIL reset_pending staged: pend got %b exp 1", load_pending); end
    for (n = 0; n < 20 && m_phase != 40; n++) cyc();
    rst = 1;
    cyc();
    rst = 0;
    vectors++;
    if (load_pending !== 1'b0 || cnt_out !== '0 || pwm_out !== IDLE || period_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_pending rst: pend got %b exp 0, cnt got %0d exp 0, pwm got %b exp %b, tick got %b exp 0",
               load_pending, cnt_out, pwm_out, IDLE, period_tick);
    end
    last_tick = -1; ticks = 0;
    for (int c = 0; c < 1200; c++) begin
      cyc();
      vectors++;
      if (pwm_out !== e_pwm || period_tick !== e_tick || load_pending !== m_pend || cnt_out !== CNT_W'(m_phase)) begin
        miscompares++;
        $display("FAIL reset_pending run: pwm got %b exp %b, tick got %b exp %b, pend got %b exp %b, cnt got %0d exp %0d",
                 pwm_out, e_pwm, period_tick, e_tick, load_pending, m_pend, cnt_out, m_phase);
      end
      if (period_tick) begin
        if (last_tick >= 0) begin
          vectors++;
          if (c - last_tick != 572) begin
            miscompares++;
            $display("FAIL reset_pending tick spacing: got %0d exp 572", c - last_tick);
          end
        end
        last_tick = c; ticks++;
      end
    end
    vectors++;
    if (ticks != 2) begin miscompares++; $display("FAIL reset_pending ticks: got %0d exp 2", ticks); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      cyc();
      vectors++;
      if (pwm_out !== e_pwm || period_tick !== e_tick || load_pending !== m_pend || cnt_out !== CNT_W'(m_phase)) begin
        miscompares++;
        $display("FAIL random c=%0d: pwm got %b exp %b, tick got %b exp %b, pend got %b exp %b, cnt got %0d exp %0d",
                 c, pwm_out, e_pwm, period_tick, e_tick, load_pending, m_pend, cnt_out, m_phase);
      end
      rst  = ($urandom_range(0, 499) == 0);
      en   = ($urandom_range(0, 19) != 0);
      load = ($urandom_range(0, 24) == 0);
      if (load) begin
        period_in = CNT_W'($urandom_range(0, 40));
        for (int i = 0; i < NUM_CH; i++) duty_in[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 45));
      end
    end
    rst = 0; load = 0; en = 1;
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_mid_reload();
    test_term_load();
    test_enable();
    test_zero_period();
    test_reset_pending();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
